// File: rtl/axi4_rd_slaver_responder_pkg.sv
// Shared definitions for the AXI4 read-only slave responder.
// Holds the AXI burst/response encodings, the control FSM state type and a
// small helper that classifies an AR request as legal or error.
package axi4_rd_slaver_responder_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Only FIXED and INCR are served from memory, and a beat may not be wider
  // than the data bus. WRAP and the reserved encoding become error bursts.
  function automatic logic burst_is_legal(input logic [1:0] burst,
                                          input logic [2:0] size,
                                          input logic [2:0] max_size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size <= max_size);
  endfunction

endpackage

// File: rtl/axi4_rd_skid_fifo.sv
// Two-entry R-channel buffer.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_push, i_data/resp/last/id   write side (ignored when full)
//   i_pop                   read side (ignored when empty)
//   o_valid, o_data/resp/last/id  head entry, held until popped
//   o_count                 occupancy 0..2
module axi4_rd_skid_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_resp,
  input  logic                  i_last,
  input  logic [ID_WIDTH-1:0]   i_id,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_resp,
  output logic                  o_last,
  output logic [ID_WIDTH-1:0]   o_id,
  output logic [1:0]            o_count
);

  logic [1:0][DATA_WIDTH-1:0] r_data;
  logic [1:0][1:0]            r_resp;
  logic [1:0]                 r_last;
  logic [1:0][ID_WIDTH-1:0]   r_id;
  logic                       r_wptr, r_rptr;
  logic [1:0]                 r_count;
  logic                       w_do_push, w_do_pop;

  assign w_do_pop  = i_pop  && (r_count != 2'd0);
  assign w_do_push = i_push && (r_count != 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_resp  <= '0;
      r_last  <= '0;
      r_id    <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_data[r_wptr] <= i_data;
        r_resp[r_wptr] <= i_resp;
        r_last[r_wptr] <= i_last;
        r_id[r_wptr]   <= i_id;
        r_wptr         <= ~r_wptr;
      end
      if (w_do_pop) r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data[r_rptr];
  assign o_resp  = r_resp[r_rptr];
  assign o_last  = r_last[r_rptr];
  assign o_id    = r_id[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/axi4_rd_slaver_responder.sv
// AXI4 read-only slave in front of a 1-cycle-latency synchronous memory.
// One burst outstanding at a time; FIXED/INCR served from memory, anything
// else answered with SLVERR beats without touching memory.
// Ports:
//   clock, rst                      clock, synchronous active-high reset
//   axi_ar*                         read address channel (slave side)
//   axi_r*                          read data channel (slave side)
//   mem_ren, mem_raddr, mem_rdata   memory read port, data 1 cycle after ren
module axi4_rd_slaver_responder
  import axi4_rd_slaver_responder_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   axi_arid,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  input  logic [2:0]            axi_arsize,
  input  logic [1:0]            axi_arburst,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [ID_WIDTH-1:0]   axi_rid,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic                  mem_ren,
  output logic [MEM_AW-1:0]     mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] LG_BYTES = 3'($clog2(DATA_WIDTH/8));

  state_e                r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic                  r_fixed;
  logic                  r_err;
  logic [7:0]            r_issue_cnt;
  logic                  r_if_vld;   // a read was issued last cycle
  logic                  r_if_last;  // ...and it was the final beat

  logic                  w_arready, w_issue, w_ar_hs, w_pop;
  logic [2:0]            w_credit;
  logic                  w_fifo_vld, w_fifo_last;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic [1:0]            w_fifo_resp;
  logic [ID_WIDTH-1:0]   w_fifo_id;
  logic [1:0]            w_fifo_count;

  assign w_ar_hs = w_arready && axi_arvalid;
  assign w_pop   = axi_rvalid && axi_rready;

  // Slots that will be occupied next cycle if nothing new is issued:
  // buffered beats plus the read whose data lands next cycle, minus a pop.
  assign w_credit = {1'b0, w_fifo_count} + {2'b00, r_if_vld} - {2'b00, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    w_arready   = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arready = 1'b1;
        if (axi_arvalid) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (w_credit < 3'd2) begin
          w_issue = 1'b1;
          if (r_issue_cnt == r_len) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop && w_fifo_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      w_arready   = 1'b0;
      w_issue     = 1'b0;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_fixed     <= 1'b0;
      r_err       <= 1'b0;
      r_issue_cnt <= '0;
      r_if_vld    <= 1'b0;
      r_if_last   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_if_vld  <= w_issue;
      r_if_last <= w_issue && (r_issue_cnt == r_len);
      if (w_ar_hs) begin
        r_id        <= axi_arid;
        r_addr      <= axi_araddr;
        r_len       <= axi_arlen;
        r_size      <= axi_arsize;
        r_fixed     <= (axi_arburst == BURST_FIXED);
        r_err       <= !burst_is_legal(axi_arburst, axi_arsize, LG_BYTES);
        r_issue_cnt <= '0;
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 8'd1;
        if (!r_fixed) r_addr <= r_addr + (ADDR_WIDTH'(1) << r_size);
      end
    end
  end

  // Error bursts walk the same issue/credit path as legal ones so timing
  // and backpressure behave identically; they just never strobe memory.
  axi4_rd_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ID_WIDTH  (ID_WIDTH)
  ) u_rbuf (
    .i_clk  (clock),
    .i_rst  (rst),
    .i_push (r_if_vld),
    .i_data (r_err ? '0 : mem_rdata),
    .i_resp (r_err ? RESP_SLVERR : RESP_OKAY),
    .i_last (r_if_last),
    .i_id   (r_id),
    .i_pop  (w_pop),
    .o_valid(w_fifo_vld),
    .o_data (w_fifo_data),
    .o_resp (w_fifo_resp),
    .o_last (w_fifo_last),
    .o_id   (w_fifo_id),
    .o_count(w_fifo_count)
  );

  // Outputs are forced to zero for the whole time rst is high, including
  // the cycle before the first reset edge.
  assign axi_arready = w_arready;
  assign axi_rvalid  = w_fifo_vld && !rst;
  assign axi_rdata   = rst ? '0 : w_fifo_data;
  assign axi_rresp   = rst ? 2'b00 : w_fifo_resp;
  assign axi_rlast   = w_fifo_last && !rst;
  assign axi_rid     = rst ? '0 : w_fifo_id;
  assign mem_ren     = w_issue && !r_err;
  assign mem_raddr   = rst ? '0 : MEM_AW'(r_addr >> LG_BYTES);

endmodule

// File: doc/axi4_rd_slaver_responder.md
AXI4_RD_SLAVER_RESPONDER -- requirements
Module: axi4_rd_slaver_responder

Interface
REQ-001 SHALL take parameters: ID_WIDTH, default 4, AXI ID width; ADDR_WIDTH, default 32, byte address width; DATA_WIDTH, default 32, data bus width (power of two, 8 to 1024); MEM_AW, default 10, memory word-address width.
REQ-002 SHALL have these ports:
- clock  in  1  single clock.
- rst  in  1  reset; synchronous and active-high.
- axi_arid  in  ID_WIDTH  read ID.
- axi_araddr  in  ADDR_WIDTH  byte start address.
- axi_arlen  in  8  beats minus 1.
- axi_arsize  in  3  log2 bytes per beat.
- axi_arburst  in  2  burst type.
- axi_arvalid  in  1  AR valid.
- axi_arready  out  1  AR ready.
- axi_rid  out  ID_WIDTH  returned ID.
- axi_rdata  out  DATA_WIDTH  read data.
- axi_rresp  out  2  response.
- axi_rlast  out  1  last beat.
- axi_rvalid  out  1  R valid.
- axi_rready  in  1  R ready.
- mem_ren  out  1  memory read strobe.
- mem_raddr  out  MEM_AW  memory word address.
- mem_rdata  in  DATA_WIDTH  memory data, valid exactly 1 cycle after mem_ren.
REQ-003 SHALL ignore arlock, arcache, arprot and arqos; they are not ports.

Function
REQ-004 SHALL implement FSM IDLE -> BURST -> DRAIN -> IDLE.
- IDLE: axi_arready=1.
- AR handshake (arvalid&arready): latch id, addr, len, size, burst; go to BURST.
- BURST: issues memory reads; moves to DRAIN once arlen+1 beats are issued.
- DRAIN: waits until the beat with rlast completes its handshake, then returns to IDLE.
REQ-005 SHALL hold axi_arready=0 in BURST and DRAIN; one outstanding burst only.
REQ-006 SHALL drive mem_raddr = current byte address >> log2(DATA_WIDTH/8), truncated to MEM_AW bits.
REQ-007 SHALL advance the beat address after each issued read:
- INCR (2'b01): add 2^arsize bytes, modulo 2^ADDR_WIDTH.
- FIXED (2'b00): keep the address constant.
REQ-008 SHALL treat WRAP (2'b10), reserved (2'b11), or arsize > log2(DATA_WIDTH/8) as an error burst:
- return arlen+1 beats with rresp=2'b10 (SLVERR) and rdata=0;
- never assert mem_ren for that burst.
REQ-009 SHALL return rresp=2'b00 (OKAY) on all beats of legal bursts, and rid = the latched arid on every beat.
REQ-010 SHALL buffer R beats in a 2-entry FIFO:
- issue a read only when (FIFO count + in-flight read − pop this cycle) < 2;
- so no beat is lost under backpressure.
REQ-011 SHALL assert rlast only on beat arlen; arlen=0 gives one beat with rlast=1.
REQ-012 SHALL keep rvalid, rdata, rresp, rid and rlast stable while rvalid=1 and rready=0.
REQ-013 SHALL meet the latency target: AR handshake in cycle T gives first mem_ren at T+1 and first rvalid at T+3.
REQ-014 SHALL sustain 1 beat/cycle with rready held high.
REQ-015 SHALL, when rready is low, stop issuing reads within the credit rule and resume with no gap once rready returns.
REQ-016 SHALL accept a new AR in the cycle after the final R handshake (IDLE), not in the same cycle.

Reset
REQ-017 SHALL, with rst=1 at a clock edge, drive the following at that edge:
- FSM to IDLE;
- FIFO empty;
- in-flight flag, beat counters and address cleared.
REQ-018 SHALL hold these reset output values while rst=1: axi_arready=0, axi_rvalid=0, axi_rlast=0, axi_rresp=0, axi_rid=0, axi_rdata=0, mem_ren=0, mem_raddr=0.
REQ-019 SHALL, on rst asserted mid-burst, abandon the burst with no further R beats; arready=1 from the first cycle after rst deasserts.

Structure
REQ-020 SHALL place the following in a shared package: burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR) and the FSM state enum.
REQ-021 SHALL implement the R buffer as sub-module axi4_rd_skid_fifo (2 entries; fields data/resp/last/id; push/pop with count output).

Verification
REQ-022 SHALL cover these directed scenarios:
- INCR single beat: arid=3, araddr=0x40, arlen=0, arsize=2, memory word16=0xA5A5A5A5 -> one beat, rdata=0xA5A5A5A5, rid=3, rresp=0, rlast=1, rvalid at T+3.
- INCR 16 beats: araddr=0x0, arlen=15, arsize=2, rready=1 -> mem_raddr 0..15 on consecutive cycles; 16 back-to-back beats; rlast on beat 15 only.
- FIXED 4 beats: araddr=0x20, arlen=3 -> mem_raddr=8 on all 4 reads; 4 beats of word8.
- Backpressure: arlen=7, rready toggled 1,0,0,1,... -> data order 0..7 intact, no beat dropped or duplicated, outputs stable while stalled.
- Error bursts: arburst=2'b10, arlen=2 -> 3 beats rresp=2'b10, rdata=0, mem_ren never 1; also arsize=3 on DATA_WIDTH=32 -> same.
- Reset mid-burst: rst=1 after beat 2 of arlen=7 -> rvalid=0 next cycle; new AR arlen=0 after reset completes normally.
